// File: rtl/network_arp_cfg_sched_if.sv
// network_arp_cfg_sched_if: config, set-IP/MAC and ARP lookup handshake bundle
interface network_arp_cfg_sched_if #(
  parameter int N_REQ = 4,
  parameter int IP_W  = 32,
  parameter int MAC_W = 48
);
  logic                  s_cfg_valid;
  logic                  s_cfg_ready;
  logic [IP_W-1:0]       s_cfg_ip;
  logic [MAC_W-1:0]      s_cfg_mac;
  logic                  m_set_ip_valid;
  logic                  m_set_ip_ready;
  logic [IP_W-1:0]       m_set_ip_data;
  logic                  m_set_mac_valid;
  logic                  m_set_mac_ready;
  logic [MAC_W-1:0]      m_set_mac_data;
  logic [N_REQ-1:0]      s_arp_valid;
  logic [N_REQ-1:0]      s_arp_ready;
  logic [N_REQ*IP_W-1:0] s_arp_data;
  logic                  m_arp_valid;
  logic                  m_arp_ready;
  logic [IP_W-1:0]       m_arp_data;
  modport slave (
    input  s_cfg_valid, s_cfg_ip, s_cfg_mac, m_set_ip_ready, m_set_mac_ready,
           s_arp_valid, s_arp_data, m_arp_ready,
    output s_cfg_ready, m_set_ip_valid, m_set_ip_data, m_set_mac_valid, m_set_mac_data,
           s_arp_ready, m_arp_valid, m_arp_data
  );
  modport master (
    output s_cfg_valid, s_cfg_ip, s_cfg_mac, m_set_ip_ready, m_set_mac_ready,
           s_arp_valid, s_arp_data, m_arp_ready,
    input  s_cfg_ready, m_set_ip_valid, m_set_ip_data, m_set_mac_valid, m_set_mac_data,
           s_arp_ready, m_arp_valid, m_arp_data
  );
endinterface

// File: rtl/network_arp_cfg_sched.sv
// network_arp_cfg_sched: IP/MAC programming sequencer plus round-robin ARP lookup arbiter
module network_arp_cfg_sched #(
  parameter int N_REQ = 4,
  parameter int IP_W  = 32,
  parameter int MAC_W = 48
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  network_arp_cfg_sched_if.slave bus,
  output logic                  configured,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic [31:0]           arp_cnt
);
  localparam int PW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, SET_IP, SET_MAC, DONE} state_t;
  state_t           state_q, state_d;
  logic [IP_W-1:0]  ip_q, arp_data_q;
  logic [MAC_W-1:0] mac_q;
  logic             configured_q, arp_valid_q, cfg_acc, gnt_found, arp_go;
  logic [PW-1:0]    ptr_q, gnt_idx;
  logic [PW:0]      t;
  logic [31:0]      cnt_q;
  // Ready is held low while reset is asserted so every handshake output reads 0 in reset
  assign bus.s_cfg_ready     = aresetn && state_q == IDLE && !arp_valid_q;
  assign cfg_acc             = bus.s_cfg_valid && bus.s_cfg_ready;
  assign bus.m_set_ip_valid  = state_q == SET_IP;
  assign bus.m_set_ip_data   = ip_q;
  assign bus.m_set_mac_valid = state_q == SET_MAC;
  assign bus.m_set_mac_data  = mac_q;
  assign bus.m_arp_valid     = arp_valid_q;
  assign bus.m_arp_data      = arp_data_q;
  assign configured          = configured_q;
  assign cfg_busy            = state_q != IDLE;
  assign cfg_done            = state_q == DONE;
  assign arp_cnt             = cnt_q;
  always_comb begin
    state_d = state_q == IDLE    ? (cfg_acc ? SET_IP : IDLE) :
              state_q == SET_IP  ? (bus.m_set_ip_ready ? SET_MAC : SET_IP) :
              state_q == SET_MAC ? (bus.m_set_mac_ready ? DONE : SET_MAC) : IDLE;
  end
  // Scan from farthest to nearest so the last hit is the first requester after ptr
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    t         = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      t = {1'b0, ptr_q} + (PW+1)'(k);
      t = t >= (PW+1)'(N_REQ) ? t - (PW+1)'(N_REQ) : t;
      if (bus.s_arp_valid[t[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = t[PW-1:0];
      end
    end
  end
  assign arp_go = state_q == IDLE && configured_q && !cfg_acc && gnt_found &&
                  (!arp_valid_q || bus.m_arp_ready);
  assign bus.s_arp_ready = arp_go ? N_REQ'(1) << gnt_idx : '0;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      ip_q         <= '0;
      mac_q        <= '0;
      configured_q <= 1'b0;
      arp_valid_q  <= 1'b0;
      arp_data_q   <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_acc) begin
        ip_q  <= bus.s_cfg_ip;
        mac_q <= bus.s_cfg_mac;
      end
      if (state_q == DONE) configured_q <= 1'b1;
      if (arp_go) begin
        arp_valid_q <= 1'b1;
        arp_data_q  <= bus.s_arp_data[gnt_idx*IP_W +: IP_W];
        ptr_q       <= gnt_idx;
      end else if (bus.m_arp_ready) begin
        arp_valid_q <= 1'b0;
      end
      if (arp_valid_q && bus.m_arp_ready) cnt_q <= cnt_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_network_arp_cfg_sched.sv
// tb_network_arp_cfg_sched: scoreboard bench for config sequencing and ARP arbitration
module tb_network_arp_cfg_sched;
  localparam int N = 4, IW = 32, MW = 48;
  logic          aclk = 1'b0, aresetn = 1'b0;
  logic          configured, cfg_busy, cfg_done;
  logic [31:0]   arp_cnt, exp_cnt;
  int            checks = 0, errors = 0, rr_ptr = 0;
  logic [IW-1:0] ip_exp[$], arp_exp[$], req_data[N], e_ip;
  logic [MW-1:0] mac_exp[$], e_mac;
  logic [N-1:0]  exp_rdy;

  network_arp_cfg_sched_if #(.N_REQ(N), .IP_W(IW), .MAC_W(MW)) bus ();

  network_arp_cfg_sched #(.N_REQ(N), .IP_W(IW), .MAC_W(MW)) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus),
    .configured(configured), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .arp_cnt(arp_cnt)
  );

  always #5 aclk = ~aclk;

  // Scoreboard: every downstream handshake pops the expectation pushed at stimulus time
  always @(negedge aclk) begin
    if (aresetn) begin
      checks++;
      if (arp_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL arp_cnt got=%0d exp=%0d", arp_cnt, exp_cnt);
      end
      if (bus.m_set_ip_valid && bus.m_set_ip_ready) begin
        checks++;
        if (ip_exp.size() == 0) begin
          errors++;
          $display("FAIL set_ip unexpected beat got=%h", bus.m_set_ip_data);
        end else begin
          e_ip = ip_exp.pop_front();
          if (bus.m_set_ip_data !== e_ip) begin
            errors++;
            $display("FAIL set_ip data got=%h exp=%h", bus.m_set_ip_data, e_ip);
          end
        end
      end
      if (bus.m_set_mac_valid && bus.m_set_mac_ready) begin
        checks++;
        if (mac_exp.size() == 0) begin
          errors++;
          $display("FAIL set_mac unexpected beat got=%h", bus.m_set_mac_data);
        end else begin
          e_mac = mac_exp.pop_front();
          if (bus.m_set_mac_data !== e_mac) begin
            errors++;
            $display("FAIL set_mac data got=%h exp=%h", bus.m_set_mac_data, e_mac);
          end
        end
      end
      if (bus.m_arp_valid && bus.m_arp_ready) begin
        checks++;
        exp_cnt++;
        if (arp_exp.size() == 0) begin
          errors++;
          $display("FAIL arp unexpected beat got=%h", bus.m_arp_data);
        end else begin
          e_ip = arp_exp.pop_front();
          if (bus.m_arp_data !== e_ip) begin
            errors++;
            $display("FAIL arp data got=%h exp=%h", bus.m_arp_data, e_ip);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    bus.s_cfg_valid = 0; bus.s_cfg_ip = '0; bus.s_cfg_mac = '0;
    bus.m_set_ip_ready = 1; bus.m_set_mac_ready = 1; bus.m_arp_ready = 1;
    bus.s_arp_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_data[i] = 32'hC0A8_0100 + IW'(i);
      bus.s_arp_data[i*IW +: IW] = req_data[i];
    end
    exp_cnt = 0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({bus.s_cfg_ready, bus.m_set_ip_valid, bus.m_set_mac_valid, bus.m_arp_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset valids/readies got=%b exp=0000",
               {bus.s_cfg_ready, bus.m_set_ip_valid, bus.m_set_mac_valid, bus.m_arp_valid});
    end
    checks++;
    if ({configured, cfg_busy, cfg_done} !== 3'b0 || arp_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset status got=%b cnt=%0d exp=000 cnt=0", {configured, cfg_busy, cfg_done}, arp_cnt);
    end
    aresetn = 1;
    @(negedge aclk);
    checks++;
    if (bus.s_cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle cfg_ready got=%b exp=1", bus.s_cfg_ready);
    end
    tick();
  endtask

  task automatic test_blocked;
    bus.s_arp_valid = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      checks++;
      if (bus.s_arp_ready !== 4'b0 || bus.m_arp_valid !== 1'b0) begin
        errors++;
        $display("FAIL blocked cyc=%0d arp_ready=%b m_valid=%b exp 0000/0", c, bus.s_arp_ready, bus.m_arp_valid);
      end
      tick();
    end
    bus.s_arp_valid = '0;
  endtask

  task automatic test_config;
    bus.s_cfg_valid = 1; bus.s_cfg_ip = 32'h0A00_000B; bus.s_cfg_mac = 48'h000A_3500_1122;
    ip_exp.push_back(32'h0A00_000B);
    mac_exp.push_back(48'h000A_3500_1122);
    @(negedge aclk);
    checks++;
    if (bus.s_cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg accept ready got=%b exp=1", bus.s_cfg_ready);
    end
    tick();
    bus.s_cfg_valid = 0;
    @(negedge aclk);
    checks++;
    if ({bus.m_set_ip_valid, bus.m_set_mac_valid, cfg_busy} !== 3'b101) begin
      errors++;
      $display("FAIL set_ip phase ip/mac/busy got=%b exp=101", {bus.m_set_ip_valid, bus.m_set_mac_valid, cfg_busy});
    end
    tick();
    @(negedge aclk);
    checks++;
    if ({bus.m_set_ip_valid, bus.m_set_mac_valid} !== 2'b01) begin
      errors++;
      $display("FAIL set_mac phase ip/mac got=%b exp=01", {bus.m_set_ip_valid, bus.m_set_mac_valid});
    end
    tick();
    @(negedge aclk);
    checks++;
    if ({cfg_done, cfg_busy, configured} !== 3'b110) begin
      errors++;
      $display("FAIL done phase done/busy/cfgd got=%b exp=110", {cfg_done, cfg_busy, configured});
    end
    tick();
    @(negedge aclk);
    checks++;
    if ({cfg_done, cfg_busy, configured} !== 3'b001) begin
      errors++;
      $display("FAIL after done done/busy/cfgd got=%b exp=001", {cfg_done, cfg_busy, configured});
    end
    tick();
  endtask

  task automatic test_set_ip_backpressure;
    bus.m_set_ip_ready = 0;
    bus.s_cfg_valid = 1; bus.s_cfg_ip = 32'hC0A8_0002; bus.s_cfg_mac = 48'h0200_0000_0002;
    ip_exp.push_back(32'hC0A8_0002);
    mac_exp.push_back(48'h0200_0000_0002);
    @(negedge aclk);
    tick();
    bus.s_cfg_valid = 0; bus.s_cfg_ip = '1; bus.s_cfg_mac = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      checks++;
      if (bus.m_set_ip_valid !== 1'b1 || bus.m_set_ip_data !== 32'hC0A8_0002 || bus.m_set_mac_valid !== 1'b0) begin
        errors++;
        $display("FAIL ip hold cyc=%0d valid=%b data=%h mac_valid=%b exp 1/c0a80002/0",
                 c, bus.m_set_ip_valid, bus.m_set_ip_data, bus.m_set_mac_valid);
      end
      tick();
    end
    bus.m_set_ip_ready = 1;
    @(negedge aclk);
    checks++;
    if (bus.m_set_mac_valid !== 1'b0) begin
      errors++;
      $display("FAIL mac early got=%b exp=0", bus.m_set_mac_valid);
    end
    tick();
    @(negedge aclk);
    checks++;
    if (bus.m_set_mac_valid !== 1'b1) begin
      errors++;
      $display("FAIL mac after ip accept got=%b exp=1", bus.m_set_mac_valid);
    end
    tick();
    @(negedge aclk);
    tick();
  endtask

  task automatic test_back_to_back;
    bus.s_arp_valid = 4'b1111;
    bus.m_arp_ready = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      rr_ptr = (rr_ptr + 1) % N;
      exp_rdy = N'(1) << rr_ptr;
      checks++;
      if (bus.s_arp_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rr grant cyc=%0d got=%b exp=%b", c, bus.s_arp_ready, exp_rdy);
      end
      arp_exp.push_back(req_data[rr_ptr]);
      tick();
    end
    bus.m_arp_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      checks++;
      if (bus.m_arp_valid !== 1'b1 || bus.m_arp_data !== req_data[rr_ptr] || bus.s_arp_ready !== 4'b0) begin
        errors++;
        $display("FAIL arp hold cyc=%0d valid=%b data=%h rdy=%b exp 1/%h/0000",
                 c, bus.m_arp_valid, bus.m_arp_data, bus.s_arp_ready, req_data[rr_ptr]);
      end
      tick();
    end
    bus.s_arp_valid = '0;
    bus.m_arp_ready = 1;
    @(negedge aclk);
    tick();
    @(negedge aclk);
    checks++;
    if (bus.m_arp_valid !== 1'b0) begin
      errors++;
      $display("FAIL arp drain valid got=%b exp=0", bus.m_arp_valid);
    end
    tick();
  endtask

  task automatic test_cfg_vs_arp;
    bus.s_cfg_valid = 1; bus.s_cfg_ip = 32'h0A00_0021; bus.s_cfg_mac = 48'h000A_3500_3344;
    bus.s_arp_valid = 4'b0100;
    ip_exp.push_back(32'h0A00_0021);
    mac_exp.push_back(48'h000A_3500_3344);
    @(negedge aclk);
    checks++;
    if (bus.s_cfg_ready !== 1'b1 || bus.s_arp_ready !== 4'b0) begin
      errors++;
      $display("FAIL simultaneous cfg_ready=%b arp_ready=%b exp 1/0000", bus.s_cfg_ready, bus.s_arp_ready);
    end
    tick();
    bus.s_cfg_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      checks++;
      if (bus.s_arp_ready !== 4'b0) begin
        errors++;
        $display("FAIL arp during cfg cyc=%0d got=%b exp=0000", c, bus.s_arp_ready);
      end
      tick();
    end
    @(negedge aclk);
    checks++;
    if (bus.s_arp_ready !== 4'b0100) begin
      errors++;
      $display("FAIL arp after done got=%b exp=0100", bus.s_arp_ready);
    end
    arp_exp.push_back(req_data[2]);
    rr_ptr = 2;
    tick();
    bus.s_arp_valid = '0;
    @(negedge aclk);
    tick();
  endtask

  task automatic test_reset_mid;
    bus.m_set_mac_ready = 0;
    bus.s_arp_valid = 4'b0001;
    bus.s_cfg_valid = 1; bus.s_cfg_ip = 32'h0A00_0031; bus.s_cfg_mac = 48'h000A_3500_5566;
    ip_exp.push_back(32'h0A00_0031);
    @(negedge aclk);
    tick();
    bus.s_cfg_valid = 0;
    @(negedge aclk);
    tick();
    @(negedge aclk);
    checks++;
    if (bus.m_set_mac_valid !== 1'b1 || bus.m_set_mac_data !== 48'h000A_3500_5566) begin
      errors++;
      $display("FAIL pre-reset mac valid=%b data=%h exp 1/000a35005566", bus.m_set_mac_valid, bus.m_set_mac_data);
    end
    #2 aresetn = 0;
    #1;
    checks++;
    if ({bus.s_cfg_ready, bus.m_set_ip_valid, bus.m_set_mac_valid, bus.m_arp_valid, bus.s_arp_ready} !== 8'b0) begin
      errors++;
      $display("FAIL async reset handshakes got=%b exp=0",
               {bus.s_cfg_ready, bus.m_set_ip_valid, bus.m_set_mac_valid, bus.m_arp_valid, bus.s_arp_ready});
    end
    checks++;
    if (bus.m_set_mac_data !== '0 || bus.m_set_ip_data !== '0 || bus.m_arp_data !== '0) begin
      errors++;
      $display("FAIL async reset data ip=%h mac=%h arp=%h exp 0", bus.m_set_ip_data, bus.m_set_mac_data, bus.m_arp_data);
    end
    checks++;
    if ({configured, cfg_busy, cfg_done} !== 3'b0 || arp_cnt !== 32'd0) begin
      errors++;
      $display("FAIL async reset status got=%b cnt=%0d exp=000 cnt=0", {configured, cfg_busy, cfg_done}, arp_cnt);
    end
    mac_exp.delete();
    arp_exp.delete();
    exp_cnt = 0;
    rr_ptr = 0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1;
    bus.m_set_mac_ready = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      checks++;
      if (bus.s_arp_ready !== 4'b0 || bus.m_arp_valid !== 1'b0 || configured !== 1'b0) begin
        errors++;
        $display("FAIL post-reset blocked cyc=%0d rdy=%b m_valid=%b cfgd=%b exp 0000/0/0",
                 c, bus.s_arp_ready, bus.m_arp_valid, configured);
      end
      tick();
    end
    bus.s_arp_valid = '0;
  endtask

  initial begin
    test_reset();
    test_blocked();
    test_config();
    test_set_ip_backpressure();
    test_back_to_back();
    test_cfg_vs_arp();
    test_reset_mid();
    checks++;
    if (ip_exp.size() != 0 || mac_exp.size() != 0 || arp_exp.size() != 0) begin
      errors++;
      $display("FAIL leftover expectations ip=%0d mac=%0d arp=%0d exp 0/0/0", ip_exp.size(), mac_exp.size(), arp_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
